// File: rtl/multicycle_mips_core.sv
// multicycle_mips_core
//   Multi-cycle MIPS-subset core built around a FETCH/DECODE/EXEC/MEM/WB state
//   machine. It sits between the instruction ROM and the data SRAM wrapper.
//   Both memories use req/ready handshakes, so either one may insert any
//   number of wait states.
//   ISA: add sub and or slt sll srl jr (R-type); addi lw sw beq bne j jal.
//
// Ports
//   clk, rst_n             clock (posedge) and synchronous active-low reset
//   imem_req/imem_addr     fetch request and byte address (= PC)
//   imem_ready/imem_rdata  fetch completion and instruction word
//   dmem_req/dmem_we       data request; we=1 for sw, 0 for lw
//   dmem_addr/dmem_wdata   word address and store data (rt value)
//   dmem_ready/dmem_rdata  data completion and load data
//   retire                 one-cycle pulse after each completed instruction
//   halted                 sticky flag set by an illegal instruction
module multicycle_mips_core #(
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter int          DMEM_AW         = 7,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ready,
  input  logic [31:0]        dmem_rdata,
  output logic               retire,
  output logic               halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        retire_q, retire_d;
  logic        halted_q, halted_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [25:0] addr26;
  logic        illegal;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] r_result;

  assign opcode      = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign shamt       = ir_q[10:6];
  assign funct       = ir_q[5:0];
  assign addr26      = ir_q[25:0];
  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {pc_plus4[31:28], addr26, 2'b00};

  // Anything outside the supported opcode/funct set is illegal.
  always_comb begin
    illegal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_SUB,
          FN_AND, FN_OR, FN_SLT: illegal = 1'b0;
          default:               illegal = 1'b1;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  // R-type ALU; slt is a true signed compare, shifts take shamt on B.
  always_comb begin
    r_result = 32'd0;
    case (funct)
      FN_ADD:  r_result = a_q + b_q;
      FN_SUB:  r_result = a_q - b_q;
      FN_AND:  r_result = a_q & b_q;
      FN_OR:   r_result = a_q | b_q;
      FN_SLT:  r_result = {31'd0, ($signed(a_q) < $signed(b_q))};
      FN_SLL:  r_result = b_q << shamt;
      FN_SRL:  r_result = b_q >> shamt;
      default: r_result = 32'd0;
    endcase
  end

  // Next-state and datapath control. The PC only moves in EXEC, so pc_q still
  // holds the current instruction's address through DECODE and EXEC.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    retire_d = 1'b0;
    halted_d = halted_q;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
        if (illegal && HALT_ON_ILLEGAL) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        pc_d     = pc_plus4;
        state_d  = S_FETCH;
        retire_d = 1'b1;
        // An illegal instruction that reaches here runs as a NOP.
        if (!illegal) begin
          case (opcode)
            OP_RTYPE: begin
              if (funct == FN_JR) begin
                pc_d = a_q;
              end else begin
                alu_d    = r_result;
                state_d  = S_WB;
                retire_d = 1'b0;
              end
            end
            OP_ADDI: begin
              alu_d    = a_q + imm_q;
              state_d  = S_WB;
              retire_d = 1'b0;
            end
            OP_LW, OP_SW: begin
              alu_d    = a_q + imm_q;
              state_d  = S_MEM;
              retire_d = 1'b0;
            end
            OP_BEQ: if (a_q == b_q) pc_d = pc_plus4 + (imm_q << 2);
            OP_BNE: if (a_q != b_q) pc_d = pc_plus4 + (imm_q << 2);
            OP_J:   pc_d = jump_target;
            OP_JAL: begin
              pc_d     = jump_target;
              rf_we    = 1'b1;
              rf_waddr = 5'd31;
              rf_wdata = pc_plus4;
            end
            default: pc_d = pc_plus4;
          endcase
        end
      end

      S_MEM: begin
        if (dmem_ready) begin
          if (opcode == OP_LW) begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
        end
      end

      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
        rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  // All state, including the register file, updates here. Reset wins over
  // any handshake in progress; writes to r0 are dropped so it stays zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      imm_q    <= 32'd0;
      alu_q    <= 32'd0;
      mdr_q    <= 32'd0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
      if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Control outputs are decoded from registered state and masked by reset so
  // they drop in the same cycle rst_n goes low.
  assign imem_req   = rst_n && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = rst_n && (state_q == S_MEM);
  assign dmem_we    = dmem_req && (opcode == OP_SW);
  assign dmem_addr  = alu_q[DMEM_AW+1:2];
  assign dmem_wdata = b_q;
  assign retire     = rst_n && retire_q;
  assign halted     = rst_n && halted_q;

endmodule
